// File: rtl/servo_sequencer.sv
// servo_sequencer: NUM_CH servo PWM outputs sharing one frame counter.
// Position commands arrive over a valid/ready handshake and set a per-channel
// target width. During the first NUM_CH cycles of every frame after the first,
// each channel's current width is moved toward its target, one channel per cycle.
// Build option SERVO_SLEW_EN: when defined, each move is limited to STEP cycles
// per frame. When undefined, the current width jumps straight to the target.
module servo_sequencer #(
  parameter int FRAME_TICKS = 1000000,
  parameter int NUM_CH      = 4,
  parameter int MIN_PULSE   = 100000,
  parameter int SCALE       = 390,
  parameter int STEP        = 5000
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic [7:0]                cmd_pos,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      frame_start,
  output logic [NUM_CH-1:0]         at_target
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(FRAME_TICKS);
  localparam int CMP_W = (CNT_W > 20) ? CNT_W : 20;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_TICKS - 1);
  localparam logic [CNT_W-1:0] LAST_CH  = CNT_W'(NUM_CH - 1);
  localparam logic [19:0] MIN_W   = 20'(MIN_PULSE);
  localparam logic [19:0] SCALE_W = 20'(SCALE);
  localparam logic [19:0] CENTER  = 20'(MIN_PULSE + 128 * SCALE);

  // The update window must finish while every output is still high, and the
  // widest pulse must end before the frame wraps.
  if ((NUM_CH < 2) || (NUM_CH > 8) || (MIN_PULSE <= NUM_CH) ||
      (MIN_PULSE + 255 * SCALE >= FRAME_TICKS) || (STEP < 1)) begin : g_bad_params
    $error("servo_sequencer: illegal parameter set");
  end

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  count_r;
  logic              frame_start_r;
  logic [19:0]       cur_r [NUM_CH];
  logic [19:0]       tgt_r [NUM_CH];
  logic              wrap_s;
  logic              accept_s;
  logic              upd_en_s;
  logic [19:0]       cmd_width_s;

`ifdef SERVO_SLEW_EN
  localparam logic [19:0] STEP_W = 20'(STEP);

  // Move cur toward tgt by at most STEP_W, landing exactly on tgt when close.
  function automatic logic [19:0] slew_step(input logic [19:0] cur, input logic [19:0] tgt);
    logic [19:0] nxt;
    if (tgt >= cur) begin
      if ((tgt - cur) <= STEP_W) nxt = tgt;
      else                       nxt = cur + STEP_W;
    end else begin
      if ((cur - tgt) <= STEP_W) nxt = tgt;
      else                       nxt = cur - STEP_W;
    end
    return nxt;
  endfunction
`endif

  assign wrap_s      = (count_r == LAST_CNT);
  assign accept_s    = cmd_valid & cmd_ready;
  assign cmd_width_s = MIN_W + (20'(cmd_pos) * SCALE_W);
  assign frame_start = frame_start_r;

  // Free-running frame counter and the registered start-of-frame strobe.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_r       <= {CNT_W{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      if (wrap_s) count_r <= {CNT_W{1'b0}};
      else        count_r <= count_r + CNT_W'(1);
      frame_start_r <= wrap_s;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (clr) state_r <= S_IDLE;
    else     state_r <= state_s;
  end

  // Next state: enter UPDATE at the wrap, leave after the last channel index.
  always_comb begin
    state_s   = state_r;
    cmd_ready = 1'b0;
    upd_en_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (wrap_s) state_s = S_UPDATE;
        else        state_s = S_IDLE;
      end
      S_UPDATE: begin
        upd_en_s = 1'b1;
        if (count_r == LAST_CH) state_s = S_IDLE;
        else                    state_s = S_UPDATE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Capture targets on accept; move the channel indexed by count during UPDATE.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (clr) begin
        cur_r[ch] <= CENTER;
        tgt_r[ch] <= CENTER;
      end else begin
        if (accept_s && (cmd_ch == CH_W'(ch))) tgt_r[ch] <= cmd_width_s;
        if (upd_en_s && (count_r == CNT_W'(ch))) begin
`ifdef SERVO_SLEW_EN
          cur_r[ch] <= slew_step(cur_r[ch], tgt_r[ch]);
`else
          cur_r[ch] <= tgt_r[ch];
`endif
        end
      end
    end
  end

  // Width compare against the shared counter; outputs are forced low in reset.
  always_comb begin
    pwm_out   = {NUM_CH{1'b0}};
    at_target = {NUM_CH{1'b0}};
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pwm_out[ch]   = ~clr & (CMP_W'(count_r) < CMP_W'(cur_r[ch]));
      at_target[ch] = (cur_r[ch] == tgt_r[ch]);
    end
  end

endmodule

// File: tb/tb_servo_sequencer.sv
// Self-checking bench for servo_sequencer with a shortened frame.
// A frame-level reference model runs alongside; hand sequences and a vector
// table cover reset, slew, handshake blocking, last-wins and reset mid-UPDATE.
module tb_servo_sequencer;

  localparam int FT     = 800;
  localparam int NCH    = 4;
  localparam int MINP   = 20;
  localparam int SC     = 3;
  localparam int ST     = 200;
  localparam int CENTER = MINP + 128 * SC;   // 404
`ifdef SERVO_SLEW_EN
  localparam int ST_EFF  = ST;
  localparam bit SLEW_ON = 1'b1;
`else
  localparam int ST_EFF  = 1 << 30;
  localparam bit SLEW_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_ch = 2'd0;
  logic [7:0]     cmd_pos = 8'd0;
  logic [NCH-1:0] pwm_out;
  logic           frame_start;
  logic [NCH-1:0] at_target;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_count   = 0;
  bit m_wrapped = 1'b0;
  int m_cur [NCH];
  int m_tgt [NCH];
  int hi [NCH];
  int last_hi [NCH];
  bit hi_ok = 1'b0;
  int frames_done = 0;

  typedef struct {
    int ch;
    int pos;
    int exp_pulse;
  } vec_t;

  servo_sequencer #(
    .FRAME_TICKS(FT), .NUM_CH(NCH), .MIN_PULSE(MINP), .SCALE(SC), .STEP(ST)
  ) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_pos(cmd_pos), .pwm_out(pwm_out),
    .frame_start(frame_start), .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic int move_toward(input int c, input int t);
    if (t - c > ST_EFF)      return c + ST_EFF;
    else if (c - t > ST_EFF) return c - ST_EFF;
    else                     return t;
  endfunction

  // One negedge of the model: compare outputs, account pulse widths, then advance.
  task automatic monitor_step();
    logic [NCH-1:0] e_pwm;
    logic [NCH-1:0] e_at;
    logic e_rdy;
    logic e_fs;
    bit   in_upd;
    in_upd = m_wrapped && (m_count < NCH);
    e_rdy  = !in_upd;
    e_fs   = m_wrapped && (m_count == 0);
    for (int ch = 0; ch < NCH; ch++) begin
      e_pwm[ch] = !clr && (m_count < m_cur[ch]);
      e_at[ch]  = (m_cur[ch] == m_tgt[ch]);
    end
    if (m_count < NCH + 2 || m_count > FT - 3 || clr || cmd_valid)
      check($sformatf("outputs cnt=%0d", m_count),
            {cmd_ready, frame_start, at_target, pwm_out}, {e_rdy, e_fs, e_at, e_pwm});
    if (m_count == 0) begin
      for (int ch = 0; ch < NCH; ch++) hi[ch] = 0;
      hi_ok = 1'b1;
    end
    if (clr) hi_ok = 1'b0;
    for (int ch = 0; ch < NCH; ch++) if (pwm_out[ch] === 1'b1) hi[ch]++;
    if (m_count == FT - 1 && hi_ok) begin
      for (int ch = 0; ch < NCH; ch++) begin
        check($sformatf("frame_pulse ch%0d", ch), hi[ch], m_cur[ch]);
        last_hi[ch] = hi[ch];
      end
      frames_done++;
    end
    if (clr) begin
      m_count = 0;
      m_wrapped = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_cur[ch] = CENTER;
        m_tgt[ch] = CENTER;
      end
    end else begin
      if (cmd_valid && e_rdy) m_tgt[cmd_ch] = MINP + int'(cmd_pos) * SC;
      if (in_upd) m_cur[m_count] = move_toward(m_cur[m_count], m_tgt[m_count]);
      if (m_count == FT - 1) begin
        m_count = 0;
        m_wrapped = 1'b1;
      end else begin
        m_count++;
      end
    end
  endtask

  // Reference model and continuous checker.
  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      m_cur[ch] = CENTER;
      m_tgt[ch] = CENTER;
      hi[ch] = 0;
      last_hi[ch] = 0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      monitor_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int ncyc);
    clr = 1'b1;
    repeat (ncyc) tick();
    clr = 1'b0;
  endtask

  task automatic wait_count(input int c);
    int n = 0;
    while (m_count != c && n < 2 * FT) begin
      tick();
      n++;
    end
    if (m_count != c) timeout_fail("wait_count");
  endtask

  task automatic wait_frames(input int k);
    int target = frames_done + k;
    int n = 0;
    while (frames_done < target && n < (k + 1) * FT + 10) begin
      tick();
      n++;
    end
    if (frames_done < target) timeout_fail("wait_frames");
  endtask

  task automatic send_cmd(input int ch, input int pos);
    logic acc = 1'b0;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_ch    = 2'(ch);
    cmd_pos   = 8'(pos);
    while (!acc && n < 2 * FT) begin
      @(negedge clk);
      acc = (cmd_ready === 1'b1);
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) timeout_fail("send_cmd");
  endtask

  initial begin
    vec_t vecs [6];
    int   i;
    vecs[0] = '{0, 0,   20};
    vecs[1] = '{1, 255, 785};
    vecs[2] = '{2, 10,  50};
    vecs[3] = '{3, 128, 404};
    vecs[4] = '{0, 200, 620};
    vecs[5] = '{3, 1,   23};

    // reset state
    do_reset(3);
    @(negedge clk);
    check("reset_ready", cmd_ready, 1);
    check("reset_at_target", at_target, 4'hF);
    check("reset_pwm", pwm_out, 4'hF);
    check("reset_frame_start", frame_start, 0);
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (frame_start !== 1'b1 && i < 2 * FT);
    check("first_frame_start_delay", i, FT);
    tick();

    // slew from center to full scale on channel 1
    send_cmd(1, 255);
    wait_frames(1);
    wait_count(1);
    @(negedge clk);
    check("slew_at_target_cnt1", at_target[1], 0);
    tick();
    @(negedge clk);
    check("slew_at_target_cnt2", at_target[1], SLEW_ON ? 0 : 1);
    wait_frames(1);
    check("slew_pulse_frame1", last_hi[1], SLEW_ON ? 604 : 785);
    wait_count(1);
    @(negedge clk);
    check("slew_final_at_target_cnt1", at_target[1], SLEW_ON ? 0 : 1);
    tick();
    @(negedge clk);
    check("slew_final_at_target_cnt2", at_target[1], 1);
    wait_frames(1);
    check("slew_pulse_frame2", last_hi[1], 785);

    // reset in the middle of an UPDATE window
    send_cmd(1, 0);
    wait_frames(1);
    wait_count(2);
    clr = 1'b1;
    @(negedge clk);
    check("clr_pwm_low", pwm_out, 4'h0);
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_ready", cmd_ready, 1);
    check("clr_at_target", at_target, 4'hF);
    check("clr_pwm_center", pwm_out, 4'hF);
    check("clr_no_frame_start", frame_start, 0);
    tick();
    wait_frames(1);
    check("clr_pulse_ch1", last_hi[1], CENTER);

    // handshake blocking across the UPDATE window
    wait_count(FT - 1);
    cmd_valid = 1'b1;
    cmd_ch    = 2'd3;
    cmd_pos   = 8'd100;
    @(negedge clk);
    check("hs_accept_at_wrap", cmd_ready, 1);
    tick();
    cmd_pos = 8'd60;
    for (int k = 0; k < NCH; k++) begin
      @(negedge clk);
      check($sformatf("hs_blocked_cnt%0d", k), cmd_ready, 0);
      tick();
    end
    @(negedge clk);
    check("hs_accept_held", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wait_frames(1);
    check("hs_pulse_first", last_hi[3], 320);
    wait_frames(1);
    check("hs_pulse_second", last_hi[3], 200);

    // last command wins
    wait_count(NCH + 5);
    cmd_valid = 1'b1;
    cmd_ch    = 2'd2;
    cmd_pos   = 8'd0;
    @(negedge clk);
    check("lw_first_ready", cmd_ready, 1);
    tick();
    cmd_pos = 8'd10;
    @(negedge clk);
    check("lw_second_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    wait_frames(4);
    check("lw_pulse", last_hi[2], 50);
    @(negedge clk);
    check("lw_at_target", at_target[2], 1);
    tick();

    // vector table: command, let it converge, check width
    for (int v = 0; v < 6; v++) begin
      send_cmd(vecs[v].ch, vecs[v].pos);
      wait_frames(5);
      check($sformatf("vec%0d_pulse", v), last_hi[vecs[v].ch], vecs[v].exp_pulse);
      @(negedge clk);
      check($sformatf("vec%0d_at_target", v), at_target[vecs[v].ch], 1);
      tick();
    end

    // random command traffic against the model
    for (int c = 0; c < 8 * FT; c++) begin
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_ch    = 2'($urandom_range(0, NCH - 1));
      cmd_pos   = 8'($urandom_range(0, 255));
      tick();
    end
    cmd_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
